// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: opcode/state enums and register-index width helper for mc_cpu_core
package mc_cpu_pkg;
    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_LD    = 4'h2,
        OP_ST    = 4'h3,
        OP_ADD   = 4'h4,
        OP_SUB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_XOR   = 4'h8,
        OP_JMP   = 4'h9,
        OP_JZ    = 4'hA,
        OP_HALT  = 4'hB,
        OP_MUL   = 4'hC,
        OP_ILL_D = 4'hD,
        OP_ILL_E = 4'hE,
        OP_ILL_F = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH0,
        S_FETCH1,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_e;

    // A single register still needs a one-bit index field.
    function automatic int reg_aw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mc_cpu_alu.sv
// mc_cpu_alu: combinational ALU (op, a, b -> y, zero); MUL only when MC_CPU_MUL_EN is defined
module mc_cpu_alu
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              zero
);
    // Unlisted opcodes pass b through, which is how LDI moves its immediate.
    always_comb begin
        y = b;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
`ifdef MC_CPU_MUL_EN
            OP_MUL:  y = a * b;
`endif
            default: y = b;
        endcase
    end

    assign zero = (y == '0);
endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: parametrised two-word multicycle CPU with ready-handshake memory port
// Ports: clk, reset (async active-low); mem_req/mem_we/mem_addr/mem_wdata registered
// requests held until mem_ready; mem_rdata sampled on req&&ready; pc, halted, illegal_op.
// Build option: MC_CPU_MUL_EN enables opcode C as MUL, otherwise C is illegal.
module mc_cpu_core
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int REG_N  = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal_op
);
    localparam int REG_AW = reg_aw(REG_N);
`ifdef MC_CPU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_e            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_regs [REG_N];
    logic [DATA_W-1:0] r_ir, r_imm, r_wdata;
    logic [ADDR_W-1:0] r_pc, r_addr;
    logic              r_req, r_we, r_z, r_halted;

    opcode_e           w_op;
    logic [REG_AW-1:0] w_rd, w_rs;
    logic [ADDR_W-1:0] w_imm_addr, w_next_pc;
    logic [DATA_W-1:0] w_alu_b, w_alu_y;
    logic              w_alu_zero, w_done, w_is_mem, w_wr, w_jump, w_bad_op, w_unused;

    assign w_op       = opcode_e'(r_ir[DATA_W-1 -: 4]);
    assign w_rd       = r_ir[2*REG_AW-1 : REG_AW];
    assign w_rs       = r_ir[REG_AW-1 : 0];
    assign w_imm_addr = ADDR_W'(r_imm);
    assign w_done     = r_req && mem_ready;
    assign w_is_mem   = (w_op == OP_LD) || (w_op == OP_ST);
    assign w_bad_op   = (w_op inside {OP_ILL_D, OP_ILL_E, OP_ILL_F}) || (w_op == OP_MUL && !MUL_EN);
    assign w_wr       = (w_op inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) || (w_op == OP_MUL && MUL_EN);
    assign w_jump     = (w_op == OP_JMP) || (w_op == OP_JZ && r_z);
    // PC already points past the immediate by EXEC, so fall-through needs no adder.
    assign w_next_pc  = w_jump ? w_imm_addr : r_pc;
    assign w_alu_b    = (w_op == OP_LDI) ? r_imm : r_regs[w_rs];
    assign w_unused   = ^r_ir;

    mc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op   (w_op),
        .a    (r_regs[w_rd]),
        .b    (w_alu_b),
        .y    (w_alu_y),
        .zero (w_alu_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH0;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH0: w_state_nxt = w_done ? S_FETCH1 : S_FETCH0;
            S_FETCH1: w_state_nxt = w_done ? S_EXEC : S_FETCH1;
            S_EXEC: begin
                w_state_nxt = w_is_mem ? S_MEM : (w_op == OP_HALT) ? S_HALTED : S_FETCH0;
                illegal_op  = w_bad_op;
            end
            S_MEM:    w_state_nxt = w_done ? S_FETCH0 : S_MEM;
            default:  w_state_nxt = S_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
            r_ir     <= '0;
            r_imm    <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
            r_addr   <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_z      <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH0: begin
                    // Only the first cycle out of reset sees FETCH0 without a live request.
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_we   <= 1'b0;
                        r_addr <= r_pc;
                    end else if (mem_ready) begin
                        r_ir   <= mem_rdata;
                        r_pc   <= r_pc + 1'b1;
                        r_addr <= r_pc + 1'b1;
                    end
                end
                S_FETCH1: begin
                    if (w_done) begin
                        r_imm <= mem_rdata;
                        r_pc  <= r_pc + 1'b1;
                        r_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (w_wr) begin
                        r_regs[w_rd] <= w_alu_y;
                        r_z          <= w_alu_zero;
                    end
                    if (w_is_mem) begin
                        r_req   <= 1'b1;
                        r_we    <= (w_op == OP_ST);
                        r_addr  <= w_imm_addr;
                        r_wdata <= r_regs[w_rs];
                    end else if (w_op == OP_HALT) begin
                        r_halted <= 1'b1;
                    end else begin
                        r_pc   <= w_next_pc;
                        r_req  <= 1'b1;
                        r_we   <= 1'b0;
                        r_addr <= w_next_pc;
                    end
                end
                S_MEM: begin
                    if (w_done) begin
                        if (!r_we) begin
                            r_regs[w_rd] <= mem_rdata;
                            r_z          <= (mem_rdata == '0);
                        end
                        r_req  <= 1'b1;
                        r_we   <= 1'b0;
                        r_addr <= r_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign pc        = r_pc;
    assign halted    = r_halted;
endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed-program bench for mc_cpu_core with a wait-state memory model
module tb_mc_cpu_core;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mem_req, mem_we, mem_ready, halted, illegal_op;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    int         t_rd [256];
    int         cyc;
    logic [7:0] stall_addr = 8'h00;
    int         stall_init = 0;
    int         stall_left, stall_seen, stall_bad;
    int         ill_hi, ill_rise;
    logic       ill_prev;
    int         n_tests = 0;
    int         n_fail = 0;

    mc_cpu_core dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = !(stall_left != 0 && mem_req && mem_addr == stall_addr);

    always @(posedge clk) begin
        if (!reset) begin
            mem        <= img;
            cyc        <= 0;
            stall_left <= stall_init;
            stall_seen <= 0;
            stall_bad  <= 0;
            for (int i = 0; i < 256; i++) t_rd[i] <= -1;
        end else begin
            cyc <= cyc + 1;
            if (mem_req && mem_ready && !mem_we) t_rd[mem_addr] <= cyc;
            if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
            if (!mem_ready) begin
                stall_left <= stall_left - 1;
                stall_seen <= stall_seen + 1;
                if (mem_we) stall_bad <= stall_bad + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            ill_hi   <= 0;
            ill_rise <= 0;
            ill_prev <= 1'b0;
        end else begin
            ill_prev <= illegal_op;
            if (illegal_op) ill_hi <= ill_hi + 1;
            if (illegal_op && !ill_prev) ill_rise <= ill_rise + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        stall_init = 0;
    endtask

    task automatic w2(input int a, input logic [7:0] w0, input logic [7:0] w1);
        img[a]     = w0;
        img[a + 1] = w1;
    endtask

    task automatic start();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_halt(input string tag);
        int k = 0;
        while (!halted && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_halt"}, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        int reqs;
        int found;

        // Program A: LDI r1,5; LDI r2,3; ADD r1,r2; ST r1,[40]; JZ 30; HALT
        clear_img();
        w2(0, 8'h14, 8'h05);
        w2(2, 8'h18, 8'h03);
        w2(4, 8'h46, 8'h00);
        w2(6, 8'h31, 8'h40);
        w2(8, 8'hA0, 8'h30);
        w2(10, 8'hB0, 8'h00);
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_pc", {24'd0, pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_illegal", {31'd0, illegal_op}, 32'd0);
        start();
        @(negedge clk);
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", {24'd0, mem_addr}, 32'd0);
        run_halt("progA");
        check("progA_m40", {24'd0, mem[8'h40]}, 32'd8);
        check("progA_add_cyc", t_rd[6] - t_rd[4], 32'd3);
        check("progA_st_cyc", t_rd[8] - t_rd[6], 32'd4);
        check("progA_jz_fall", t_rd[10] - t_rd[8], 32'd3);
        check("progA_pc", {24'd0, pc}, 32'h0C);
        reqs = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        check("halt_no_req", reqs, 32'd0);
        check("halt_stays", {31'd0, halted}, 32'd1);

        // Reset during FETCH1 of the first instruction, then clean restart of program A
        start();
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 8'h01) found = 1;
        end
        check("f1_found", found, 32'd1);
        reset = 1'b0;
        #1;
        check("async_req", {31'd0, mem_req}, 32'd0);
        check("async_addr", {24'd0, mem_addr}, 32'd0);
        check("async_pc", {24'd0, pc}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("restart_req", {31'd0, mem_req}, 32'd1);
        check("restart_addr", {24'd0, mem_addr}, 32'd0);
        check("restart_pc", {24'd0, pc}, 32'd0);
        run_halt("restart");
        check("restart_m40", {24'd0, mem[8'h40]}, 32'd8);

        // SUB to zero then JZ 20: taken
        clear_img();
        w2(0, 8'h14, 8'h07);
        w2(2, 8'h18, 8'h07);
        w2(4, 8'h56, 8'h00);
        w2(6, 8'hA0, 8'h20);
        w2(8, 8'hB0, 8'h00);
        w2(8'h20, 8'hB0, 8'h00);
        start();
        run_halt("jz_taken");
        check("jz_taken_pc", {24'd0, pc}, 32'h22);
        check("jz_taken_cyc", t_rd[8'h20] - t_rd[6], 32'd3);

        // SUB to nonzero then JZ 20: falls through
        img[3] = 8'h06;
        start();
        run_halt("jz_fall");
        check("jz_fall_pc", {24'd0, pc}, 32'h0A);

        // LD r0,[10] with three wait states; ST r0,[41]; HALT
        clear_img();
        w2(0, 8'h20, 8'h10);
        w2(2, 8'h30, 8'h41);
        w2(4, 8'hB0, 8'h00);
        img[8'h10] = 8'h5A;
        stall_addr = 8'h10;
        stall_init = 3;
        start();
        run_halt("ld_wait");
        check("ld_wait_cyc", t_rd[2] - t_rd[0], 32'd7);
        check("ld_stall_seen", stall_seen, 32'd3);
        check("ld_stall_bad", stall_bad, 32'd0);
        check("ld_m41", {24'd0, mem[8'h41]}, 32'h5A);
        check("ld_pc", {24'd0, pc}, 32'h06);

        // Opcode E (always illegal) and opcode C on r1=9, then ST r1,[42]
        clear_img();
        w2(0, 8'h14, 8'h09);
        w2(2, 8'hE5, 8'h00);
        w2(4, 8'hC5, 8'h00);
        w2(6, 8'h31, 8'h42);
        w2(8, 8'hB0, 8'h00);
        start();
        run_halt("illegal");
        check("ill_next_fetch", t_rd[4] - t_rd[2], 32'd3);
`ifdef MC_CPU_MUL_EN
        check("ill_m42", {24'd0, mem[8'h42]}, 32'h51);
        check("ill_cycles", ill_hi, 32'd1);
        check("ill_pulses", ill_rise, 32'd1);
`else
        check("ill_m42", {24'd0, mem[8'h42]}, 32'h09);
        check("ill_cycles", ill_hi, 32'd2);
        check("ill_pulses", ill_rise, 32'd2);
`endif

        // MUL 10*10 -> 0 with Z set; without MUL it is a NOP and Z stays clear
        clear_img();
        w2(0, 8'h14, 8'h10);
        w2(2, 8'h18, 8'h10);
        w2(4, 8'hC6, 8'h00);
        w2(6, 8'h31, 8'h43);
        w2(8, 8'hA0, 8'h20);
        w2(10, 8'hB0, 8'h00);
        w2(8'h20, 8'hB0, 8'h00);
        img[8'h43] = 8'hFF;
        start();
        run_halt("mul");
`ifdef MC_CPU_MUL_EN
        check("mul_m43", {24'd0, mem[8'h43]}, 32'h00);
        check("mul_pc", {24'd0, pc}, 32'h22);
`else
        check("mul_m43", {24'd0, mem[8'h43]}, 32'h10);
        check("mul_pc", {24'd0, pc}, 32'h0C);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Parametrised multicycle CPU core, the successor to the 8-bit multicycle CPU top. It is generalised in data width, address width and register count. It adds a ready-based memory handshake so memory may insert wait states, a zero-flag conditional branch, HALT, and illegal-opcode reporting. It sits between the system memory/bus and the debug or test harness, and it replaces the fixed 8-bit decoder/datapath pair.

## Interface
- DATA_W, 8, datapath and memory word width; constraint: DATA_W ≥ 4 + 2·REG_AW.
- ADDR_W, 8, memory address width; PC width.
- REG_N, 4, number of general registers; REG_AW = $clog2(REG_N).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; sampled in the cycle where mem_req && mem_ready.
- mem_ready  in  1  completes the current transaction.
- pc  out  ADDR_W  current program counter.
- halted  out  1  core stopped by HALT.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Every instruction is two words at PC and PC+1.
- Word0 fields:
  - opcode = [DATA_W-1 -: 4]
  - rd = [2·REG_AW-1 : REG_AW]
  - rs = [REG_AW-1 : 0]
- Word1 is imm. Addresses use imm[ADDR_W-1:0], zero-extended if ADDR_W > DATA_W.
- Opcodes:
  - 0 NOP
  - 1 LDI rd←imm
  - 2 LD rd←M[imm]
  - 3 ST M[imm]←rs
  - 4 ADD rd←rd+rs
  - 5 SUB rd←rd−rs
  - 6 AND
  - 7 OR
  - 8 XOR
  - 9 JMP pc←imm
  - A JZ: pc←imm if Z, else fall through
  - B HALT
  - C MUL (see Configuration)
  - D–F illegal: pulse illegal_op, then behave as NOP.
- Z flag:
  - Updated by ADD/SUB/AND/OR/XOR/MUL/LDI/LD: Z = (result == 0).
  - Unchanged by all other opcodes.
- Arithmetic is modulo 2^DATA_W; carry is discarded.
- PC wraps modulo 2^ADDR_W.
- FSM states and transitions:
  - FETCH0: read PC into IR0, then go to FETCH1.
  - FETCH1: read PC+1 into IMM, then go to EXEC.
  - EXEC:
    - ALU ops, LDI, jumps, NOP and illegal opcodes: write back and set PC, then go to FETCH0.
    - LD/ST: go to MEM.
    - HALT: go to HALTED.
  - MEM: perform the LD/ST transaction, then go to FETCH0.
  - HALTED: absorbing; only reset exits.
- PC advances by 1 on each completed fetch. JMP/JZ overwrite PC in EXEC.
- Register writes occur only in EXEC or at LD completion.

## Timing
- Reset values:
  - pc = 0, all registers = 0, Z = 0
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - halted = 0, illegal_op = 0
  - state = FETCH0
- The first mem_req is asserted in the first cycle after reset deassertion.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until mem_ready.
  - A transaction completes in the cycle mem_req && mem_ready.
  - mem_req may be asserted back-to-back with the next transaction.
- With zero wait states (mem_ready held high):
  - ALU/LDI/JMP/JZ/NOP: 3 cycles.
  - LD/ST: 4 cycles.
- Each wait cycle adds one cycle; the state does not change while mem_ready = 0.
- mem_ready while mem_req = 0 is ignored.
- Reset asserted mid-transaction forces mem_req low asynchronously. Any partial instruction is discarded.
- illegal_op is high for exactly the EXEC cycle.
- halted rises on the cycle after HALT's EXEC. mem_req stays 0 while halted.

## Configuration
- MC_CPU_MUL_EN defined: opcode C is MUL, rd←(rd·rs)[DATA_W-1:0], still single-cycle EXEC; Z is updated.
- MC_CPU_MUL_EN undefined: opcode C is illegal (illegal_op pulse, NOP behaviour), and no multiplier is synthesised.

## Structure
- Package mc_cpu_pkg holds:
  - opcode_e enum (4-bit) and state_e enum
  - function computing REG_AW
- Sub-module mc_cpu_alu:
  - Combinational, parametrised by DATA_W.
  - Inputs: op, a, b. Outputs: y, zero.
  - MUL is guarded by MC_CPU_MUL_EN.
- Register file, IR/IMM registers and the FSM live in mc_cpu_core.

## Test plan
- LDI r1,5; LDI r2,3; ADD r1,r2; ST r1,[0x40] with mem_ready = 1 → M[0x40] = 8; Z = 0; ADD takes 3 cycles and ST takes 4.
- SUB reaching 0, then JZ 0x20 → pc = 0x20; same sequence with a nonzero result → pc falls through to the next instruction.
- LD r0,[0x10] with mem_ready low for 3 cycles → mem_addr/mem_req held stable; r0 = M[0x10] one cycle after mem_ready; total 7 cycles.
- Opcode 0xE → illegal_op high for 1 cycle; registers unchanged; next fetch at PC+2. Opcode C without MC_CPU_MUL_EN behaves the same way.
- MUL 0x10·0x10 with DATA_W = 8 and MC_CPU_MUL_EN defined → rd = 0x00, Z = 1.
- Reset asserted while mem_req is high during FETCH1 → mem_req = 0 immediately; after release, mem_addr = 0 and pc = 0. HALT → halted = 1 and no further mem_req.
